// File: rtl/tp_row_reassembler.sv
// Double-buffered 8x8 column-to-row reassembler: accepts column bursts from the transpose
// memory and streams the block back out row by row through a valid/ready handshake.
module tp_row_reassembler #(
   parameter int BW = 12
) (
   input  logic            i_clk,
   input  logic            i_Reset,
   input  logic [8*BW-1:0] i_data,
   input  logic            i_en,
   output logic            o_in_ready,
   output logic [8*BW-1:0] o_data,
   output logic            o_valid,
   input  logic            i_ready,
   output logic            o_ovf
);
   localparam int VW = 8 * BW;

   logic [VW-1:0] mem_q [2][8];

   logic       wbank_q, wbank_d;
   logic       rbank_q, rbank_d;
   logic [2:0] wcnt_q, wcnt_d;
   logic [2:0] rcnt_q, rcnt_d;
   logic [1:0] full_q, full_d;
   logic       ovf_q, ovf_d;

   logic          wr_acc;
   logic          rd_xfer;
   logic [VW-1:0] row_data;

   // Handshake flags come from registered state only, so a bank freed this
   // cycle is not writable until the next one.
   assign o_in_ready = ~full_q[wbank_q];
   assign o_valid    = full_q[rbank_q];
   assign o_ovf      = ovf_q;
   assign wr_acc     = i_en & o_in_ready;
   assign rd_xfer    = o_valid & i_ready;

   always_comb begin
      wbank_d = wbank_q;
      rbank_d = rbank_q;
      wcnt_d  = wcnt_q;
      rcnt_d  = rcnt_q;
      full_d  = full_q;
      ovf_d   = ovf_q;

      if (wr_acc) begin
         wcnt_d = wcnt_q + 3'd1;
         if (wcnt_q == 3'd7) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
         end
      end else if (i_en) begin
         ovf_d = 1'b1;
      end

      // A completing read always targets the other bank than a completing write.
      if (rd_xfer) begin
         rcnt_d = rcnt_q + 3'd1;
         if (rcnt_q == 3'd7) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = ~rbank_q;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_Reset) begin
         wbank_q <= 1'b0;
         rbank_q <= 1'b0;
         wcnt_q  <= 3'd0;
         rcnt_q  <= 3'd0;
         full_q  <= 2'b00;
         ovf_q   <= 1'b0;
      end else begin
         wbank_q <= wbank_d;
         rbank_q <= rbank_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
         full_q  <= full_d;
         ovf_q   <= ovf_d;
      end
   end

   // Bank contents are never reset; the output mask hides stale data.
   always_ff @(posedge i_clk) begin
      if (wr_acc) begin
         mem_q[wbank_q][wcnt_q] <= i_data;
      end
   end

   // Row element j is element rcnt of stored column j.
   always_comb begin
      row_data = '0;
      for (int j = 0; j < 8; j++) begin
         for (int r = 0; r < 8; r++) begin
            if (rcnt_q == 3'(r)) begin
               row_data[VW-1-j*BW -: BW] = mem_q[rbank_q][j][VW-1-r*BW -: BW];
            end
         end
      end
   end

   assign o_data = o_valid ? row_data : '0;

endmodule

// File: tb/tb_tp_row_reassembler.sv
// Scoreboard bench for tp_row_reassembler: stimulus pushes expected rows, a negedge
// monitor pops them on every transfer and checks hold-stability during stalls.
module tb_tp_row_reassembler;
   localparam int BW = 12;
   localparam int VW = 8 * BW;

   logic          i_clk = 1'b0;
   logic          i_Reset;
   logic [VW-1:0] i_data;
   logic          i_en;
   logic          o_in_ready;
   logic [VW-1:0] o_data;
   logic          o_valid;
   logic          i_ready;
   logic          o_ovf;

   tp_row_reassembler #(.BW(BW)) dut (
      .i_clk      (i_clk),
      .i_Reset    (i_Reset),
      .i_data     (i_data),
      .i_en       (i_en),
      .o_in_ready (o_in_ready),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_ovf      (o_ovf)
   );

   always #5 i_clk = ~i_clk;

   int            n_vec = 0;
   int            n_err = 0;
   logic [VW-1:0] exp_q [$];
   logic          prev_stall = 1'b0;
   logic [VW-1:0] prev_data = '0;

   task automatic check(input string name, input logic [VW:0] act, input logic [VW:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [VW-1:0] make_col(input int base, input int c);
      logic [VW-1:0] v;
      v = '0;
      for (int r = 0; r < 8; r++) v[VW-1-r*BW -: BW] = 12'(base + 16*r + c);
      return v;
   endfunction

   function automatic logic [VW-1:0] make_row(input int base, input int r);
      logic [VW-1:0] v;
      v = '0;
      for (int j = 0; j < 8; j++) v[VW-1-j*BW -: BW] = 12'(base + 16*r + j);
      return v;
   endfunction

   task automatic push_block(input int base);
      for (int r = 0; r < 8; r++) exp_q.push_back(make_row(base, r));
   endtask

   // One beat per call: drive after the edge, sampled at the following edge.
   task automatic send_beat(input logic [VW-1:0] d);
      i_en   = 1'b1;
      i_data = d;
      @(posedge i_clk);
      #1;
      i_en   = 1'b0;
   endtask

   task automatic send_block(input int base);
      for (int c = 0; c < 8; c++) begin
         if (c == 7) push_block(base);
         send_beat(make_col(base, c));
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      check("drain_remaining", (VW+1)'(exp_q.size()), '0);
      @(negedge i_clk);
      check("valid_after_drain", {{VW{1'b0}}, o_valid}, '0);
      @(posedge i_clk);
      #1;
   endtask

   // Monitor: pop on every transfer, enforce zero data when idle and hold during stall.
   always @(negedge i_clk) begin
      if (i_Reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check("stall_hold", {o_valid, o_data}, {1'b1, prev_data});
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_row", {1'b1, o_data}, '0);
            end else begin
               logic [VW-1:0] e;
               e = exp_q.pop_front();
               check("row", {1'b0, o_data}, {1'b0, e});
               $display("row transfer data=%h expected=%h", o_data, e);
            end
         end else if (!o_valid) begin
            check("idle_zero", {1'b0, o_data}, '0);
         end
         prev_stall = o_valid && !i_ready;
         prev_data  = o_data;
      end
   end

   initial begin
      // Reset with random inputs
      i_Reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         i_data  = {$urandom, $urandom, $urandom};
         i_en    = 1'($urandom);
         i_ready = 1'($urandom);
         @(posedge i_clk);
      end
      @(negedge i_clk);
      check("rst_valid", {{VW{1'b0}}, o_valid}, '0);
      check("rst_data", {1'b0, o_data}, '0);
      check("rst_ovf", {{VW{1'b0}}, o_ovf}, '0);
      check("rst_in_ready", {{VW{1'b0}}, o_in_ready}, (VW+1)'(1));
      @(posedge i_clk);
      #1;
      i_Reset = 1'b0;
      i_en    = 1'b0;
      i_data  = '0;
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;

      // Single block: valid the cycle after beat 8, exactly 8 consecutive rows
      send_block(0);
      for (int i = 0; i < 9; i++) begin
         @(negedge i_clk);
         check("single_valid", {{VW{1'b0}}, o_valid}, (VW+1)'(i < 8));
      end
      wait_drain();

      // Gapped input and stalled output
      i_ready = 1'b0;
      for (int c = 0; c < 4; c++) send_beat(make_col('h500, c));
      repeat (3) @(posedge i_clk);
      #1;
      push_block('h500);
      for (int c = 4; c < 8; c++) send_beat(make_col('h500, c));
      repeat (5) @(posedge i_clk);
      #1;
      i_ready = 1'b1;
      wait_drain();

      // Ping-pong: no bubble between blocks
      send_block('h000);
      fork
         send_block('h100);
         begin
            for (int i = 0; i < 17; i++) begin
               @(negedge i_clk);
               check("pingpong_valid", {{VW{1'b0}}, o_valid}, (VW+1)'(i < 16));
            end
         end
      join
      wait_drain();

      // Overflow: both banks full, 17th beat dropped
      i_ready = 1'b0;
      send_block('h200);
      send_block('h300);
      @(negedge i_clk);
      check("ovf_in_ready", {{VW{1'b0}}, o_in_ready}, '0);
      check("ovf_before", {{VW{1'b0}}, o_ovf}, '0);
      @(posedge i_clk);
      #1;
      send_beat(make_col('h700, 0));
      @(negedge i_clk);
      check("ovf_set", {{VW{1'b0}}, o_ovf}, (VW+1)'(1));
      @(posedge i_clk);
      #1;
      i_ready = 1'b1;
      wait_drain();
      check("ovf_sticky", {{VW{1'b0}}, o_ovf}, (VW+1)'(1));
      check("in_ready_after_drain", {{VW{1'b0}}, o_in_ready}, (VW+1)'(1));

      // Reset mid-block discards the partial block
      for (int c = 0; c < 5; c++) send_beat(make_col('h600, c));
      i_Reset = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      i_Reset = 1'b0;
      @(negedge i_clk);
      check("midrst_ovf", {{VW{1'b0}}, o_ovf}, '0);
      check("midrst_valid", {{VW{1'b0}}, o_valid}, '0);
      @(posedge i_clk);
      #1;
      send_block('h400);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/tp_row_reassembler.md
# tp_row_reassembler

Inverse-side partner of the 8x8 transpose memory: accepts the column-major bursts the transpose memory emits (one 8-element column per enable beat) and reassembles them into the original row-major order. It is double-buffered so the next 8x8 block can be written while the current one drains. Rows leave through a valid/ready handshake so a stalling downstream stage does not lose data. It sits directly after the transpose stage in the 2-D transform pipeline.

## Interface
- BW, 12, bit width of one matrix element; one vector is 8 elements, 8*BW bits.
- i_clk  input  1  clock; all state updates on rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_data  input  8*BW  column vector; element 0 in bits [8*BW-1:7*BW], element 7 in bits [BW-1:0].
- i_en  input  1  column beat qualifier; one column is written per cycle with i_en=1.
- o_in_ready  output  1  write bank has space; i_en beats while 0 are dropped.
- o_data  output  8*BW  reassembled row, element 0 in the MSB slot; all zeros while o_valid=0.
- o_valid  output  1  o_data holds a valid row.
- i_ready  input  1  downstream accepts the row; a transfer happens when o_valid & i_ready.
- o_ovf  output  1  sticky overflow flag: a beat was dropped.

## Operation
- Storage: two banks (0,1), each holds 8 columns of 8*BW bits, plus full[1:0] flags.
- Write side: wbank pointer, 3-bit wcnt. An accepted beat (i_en & o_in_ready) stores i_data into column wcnt of bank wbank and increments wcnt. On the 8th beat (wcnt=7), full[wbank] is set, wcnt wraps to 0, and wbank toggles.
- Beats need not be consecutive. Gaps with i_en=0 hold wcnt.
- o_in_ready = ~full[wbank], decoded from registered state only.
- A beat with i_en=1 while o_in_ready=0 is discarded. No storage or counter changes, and o_ovf is set. o_ovf clears only on reset.
- Read side: rbank pointer, 3-bit rcnt. o_valid = full[rbank].
- Row r output: element j of row r (slot [8*BW-1-j*BW -: BW]) = element r of stored column j of bank rbank.
- On each transfer, rcnt increments. On the transfer with rcnt=7, full[rbank] is cleared, rcnt wraps to 0, and rbank toggles.
- Simultaneous events:
  - A write completing bank A and a read completing bank B in the same cycle both take effect.
  - A bank freed by a read in cycle t is writable from cycle t+1. A beat offered in cycle t sees o_in_ready=0 and is dropped.
- Reset clears all pointers, counters, full flags and o_ovf. Bank contents need not be cleared, because o_data is masked to 0 when o_valid=0.
- Reset mid-block discards any partial or unread block.

## Timing
- Reset values:
  - o_valid=0, o_data=0, o_ovf=0.
  - o_in_ready=1.
- Latency: the 8th column beat in cycle t gives o_valid=1 with row 0 in cycle t+1, when the read bank is empty.
- Throughput: with i_ready held 1 and back-to-back blocks, the output streams 8 rows per 8 input beats continuously after the first 1-cycle latency.
- o_data and o_valid stay stable while o_valid & ~i_ready.
- Both banks full gives o_in_ready=0 until the first bank fully drains.

## Test plan
- Reset: hold i_Reset=1 for 2 cycles with random inputs -> o_valid=0, o_data=0, o_ovf=0, o_in_ready=1.
- Single block (BW=12): 8 beats, column c carrying element r = 16*r+c, with i_ready=1 -> starting the cycle after beat 8, row r carries elements 16*r+0..16*r+7 for r=0..7, in 8 consecutive cycles. o_valid then drops.
- Gapped input and stalled output: insert 3 idle cycles between beats 4 and 5, and hold i_ready=0 for 5 cycles after o_valid rises -> row 0 is held stable, all 8 rows are still correct, and no row is lost or duplicated.
- Ping-pong: two blocks back-to-back with i_ready=1 (block B = block A + 0x100) -> 16 rows in order, with no gap between row 7 of A and row 0 of B.
- Overflow: hold i_ready=0 and send 17 beats -> o_in_ready=0 after beat 16, beat 17 is dropped, o_ovf=1. After both banks drain, both blocks are intact and o_ovf stays 1.
- Reset mid-operation: assert i_Reset after 5 beats of a block, then send a fresh full block -> only the fresh block's 8 rows appear, correct.
